dmem_responder: RTL and testbench

Data-side memory responder for the pipelined RV32IM core: the slave end of the MEM-stage interface (word address, write data, write strobe, byte enables, combinational read word). It holds a word-organised data RAM with byte-lane write steering and a small memory-mapped I/O page containing a 64-bit cycle counter and a console transmit FIFO with a valid/ready drain port. It sits beside the core at top level, wired to ALUResultM, WriteDataM, MemWriteM, byteEnable and RD_data.

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-side memory responder: word RAM, cycle counter, console TX FIFO
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic [31:0] i_a,
  input  logic [31:0] i_wd,
  input  logic        i_we,
  input  logic [3:0]  i_be,
  output logic [31:0] o_rd,
  output logic [7:0]  o_cons_data,
  output logic        o_cons_valid,
  input  logic        i_cons_ready
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam int unsigned FAW = $clog2(FIFO_DEPTH);
  localparam logic [FAW:0] FULL_CNT = FIFO_DEPTH[FAW:0];

  // Storage and MMIO state
  logic [31:0]    r_mem  [DEPTH_WORDS];
  logic [7:0]     r_fifo [FIFO_DEPTH];
  logic [FAW-1:0] r_wptr;
  logic [FAW-1:0] r_rptr;
  logic [FAW:0]   r_count;
  logic           r_ovf;
  logic [63:0]    r_cycle;

  // Decode and control
  logic          w_mmio;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic [31:0]   w_lane_data;
  logic          w_ram_we;
  logic          w_push_req;
  logic          w_clr_req;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [31:0]   w_count32;
  logic [3:0]    w_cnt_disp;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_mmio   = (i_a[31:4] == MMIO_BASE[31:4]);
  assign w_idx    = i_a[AW+1:2];
  assign w_off    = i_a[3:2];
  assign w_unused = ^i_a[1:0];

  assign w_ram_we   = i_we & ~w_mmio & ~i_clr;
  assign w_push_req = i_we & w_mmio & (w_off == 2'd0) & i_be[0];
  assign w_clr_req  = i_we & w_mmio & (w_off == 2'd1) & i_be[0] & i_wd[2];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = ~w_empty & i_cons_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & w_full & ~w_pop;

  assign w_count32  = 32'(r_count);
  assign w_cnt_disp = (w_count32 > 32'd15) ? 4'd15 : w_count32[3:0];
  assign w_status   = {24'b0, w_cnt_disp, 1'b0, r_ovf, w_empty, w_full};

  // Head byte is masked to zero when empty so the port reads 0 after reset.
  assign o_cons_valid = ~w_empty;
  assign o_cons_data  = w_empty ? 8'h00 : r_fifo[r_rptr];

  // Replicate store data across lanes according to the access size implied by be
  always_comb begin
    w_lane_data = {4{i_wd[7:0]}};
    case (i_be)
      4'b1111:          w_lane_data = i_wd;
      4'b0011, 4'b1100: w_lane_data = {i_wd[15:0], i_wd[15:0]};
      default:          w_lane_data = {4{i_wd[7:0]}};
    endcase
  end

  // Byte-lane RAM write; contents survive reset
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_ram_we && i_be[k]) begin
        r_mem[w_idx][8*k +: 8] <= w_lane_data[8*k +: 8];
      end
    end
  end

  // FIFO data storage write
  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) begin
      r_fifo[r_wptr] <= i_wd[7:0];
    end
  end

  // Cycle counter, FIFO pointers/count and sticky overflow
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cycle <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Setting wins over a same-cycle clear.
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_clr_req) r_ovf <= 1'b0;
    end
  end

  // Combinational read mux: RAM word or MMIO register
  always_comb begin
    o_rd = '0;
    if (w_mmio) begin
      case (w_off)
        2'd0:    o_rd = '0;
        2'd1:    o_rd = w_status;
        2'd2:    o_rd = r_cycle[31:0];
        default: o_rd = r_cycle[63:32];
      endcase
    end else begin
      o_rd = r_mem[w_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int DW = 1024;
  localparam int FD = 8;
  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] a, wd, rd;
  logic        we;
  logic [3:0]  be;
  logic [7:0]  cd;
  logic        cv, cr;

  dmem_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD), .MMIO_BASE(MB)) dut (
    .i_clk(clk), .i_clr(clr), .i_a(a), .i_wd(wd), .i_we(we), .i_be(be),
    .o_rd(rd), .o_cons_data(cd), .o_cons_valid(cv), .i_cons_ready(cr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model
  logic [31:0] m_mem [int];
  logic [7:0]  m_q [$];
  logic        m_ovf;
  logic [63:0] m_cyc;

  logic [31:0] last_rd;
  logic [7:0]  last_cd;
  logic        last_cv;
  logic        rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_status();
    int n;
    logic [3:0] c;
    n = m_q.size();
    c = (n > 15) ? 4'd15 : 4'(n);
    return {24'b0, c, 1'b0, m_ovf, (n == 0), (n == FD)};
  endfunction

  function automatic bit m_read(input logic [31:0] ad, output logic [31:0] v);
    int idx;
    v = '0;
    if (ad[31:4] == MB[31:4]) begin
      case (ad[3:2])
        2'd0: v = 32'h0;
        2'd1: v = m_status();
        2'd2: v = m_cyc[31:0];
        default: v = m_cyc[63:32];
      endcase
      return 1'b1;
    end
    idx = (ad / 4) % DW;
    if (!m_mem.exists(idx)) return 1'b0;
    v = m_mem[idx];
    return !$isunknown(v);
  endfunction

  task automatic cyc(input logic [31:0] ia, input logic [31:0] iwd, input logic iwe,
                     input logic [3:0] ibe, input logic icr, input logic iclr);
    logic [31:0] exp, w;
    bit known, mmio, pop, full;
    int idx;
    @(negedge clk);
    a = ia; wd = iwd; we = iwe; be = ibe; cr = icr; clr = iclr;
    #1;
    last_rd = rd; last_cd = cd; last_cv = cv;
    known = m_read(ia, exp);
    if (known) check("rd", rd, exp);
    check("cons_valid", cv, m_q.size() != 0);
    check("cons_data", cd, (m_q.size() != 0) ? m_q[0] : 8'h00);
    // state after the coming edge
    if (iclr) begin
      m_cyc = 0; m_q.delete(); m_ovf = 1'b0;
    end else begin
      m_cyc = m_cyc + 1;
      mmio = (ia[31:4] == MB[31:4]);
      if (iwe && !mmio) begin
        idx = (ia / 4) % DW;
        w = m_mem.exists(idx) ? m_mem[idx] : 32'hxxxx_xxxx;
        for (int i = 0; i < 4; i++) begin
          if (ibe[i]) begin
            if (ibe == 4'hF) w[8*i +: 8] = iwd[8*i +: 8];
            else if (ibe == 4'h3 || ibe == 4'hC) w[8*i +: 8] = iwd[8*(i%2) +: 8];
            else w[8*i +: 8] = iwd[7:0];
          end
        end
        m_mem[idx] = w;
      end
      pop  = (m_q.size() != 0) && icr;
      full = (m_q.size() == FD);
      if (pop) void'(m_q.pop_front());
      if (iwe && mmio && ia[3:2] == 2'd0 && ibe[0]) begin
        if (!full || pop) m_q.push_back(iwd[7:0]);
        else m_ovf = 1'b1;
      end else if (iwe && mmio && ia[3:2] == 2'd1 && ibe[0] && iwd[2]) begin
        m_ovf = 1'b0;
      end
    end
  endtask

  task automatic wr(input logic [31:0] ad, input logic [31:0] d, input logic [3:0] b);
    cyc(ad, d, 1'b1, b, rdy, 1'b0);
  endtask

  task automatic rdck(input string tag, input logic [31:0] ad, input logic [31:0] exp);
    cyc(ad, 32'h0, 1'b0, 4'h0, rdy, 1'b0);
    check(tag, last_rd, exp);
  endtask

  task automatic idle();
    cyc(32'h0, 32'h0, 1'b0, 4'h0, rdy, 1'b0);
  endtask

  initial begin
    a = 0; wd = 0; we = 0; be = 0; cr = 0; clr = 1; rdy = 0;
    repeat (2) @(posedge clk);
    m_cyc = 0; m_ovf = 0; m_q.delete();

    // reset state and cycle counter start
    rdck("cycle_lo_0", MB + 8, 32'd0);
    check("reset_valid", last_cv, 1'b0);
    check("reset_data", last_cd, 8'h00);
    repeat (3) idle();
    rdck("status_reset", MB + 4, 32'h0000_0002);
    rdck("cycle_lo_5", MB + 8, 32'd5);

    // byte-lane steering
    wr(32'h100, 32'hDEAD_BEEF, 4'hF);
    wr(32'h101, 32'h0000_00AA, 4'h2);
    rdck("sb_lane", 32'h100, 32'hDEAD_AAEF);
    wr(32'h102, 32'h1234_5678, 4'hC);
    rdck("sh_upper", 32'h100, 32'h5678_AAEF);
    wr(32'h100, 32'hFFFF_FFFF, 4'h0);
    rdck("be_zero", 32'h100, 32'h5678_AAEF);
    wr(32'h100 + 4 * DW, 32'hCAFE_F00D, 4'hF);
    rdck("alias", 32'h100, 32'hCAFE_F00D);
    // same-cycle read of written word returns old data
    wr(32'h100, 32'h1111_2222, 4'hF);
    check("write_old_data", last_rd, 32'hCAFE_F00D);
    rdck("write_new_data", 32'h100, 32'h1111_2222);

    // overflow and drain
    rdy = 0;
    for (int i = 0; i < 9; i++) wr(MB, 32'h41 + i, 4'h1);
    rdck("status_full_ovf", MB + 4, 32'h0000_0085);
    rdy = 1;
    for (int i = 0; i < 8; i++) begin
      idle();
      check("drain_byte", last_cd, 8'(8'h41 + i));
    end
    idle();
    check("drained_valid", last_cv, 1'b0);
    rdck("status_empty_ovf", MB + 4, 32'h0000_0006);
    wr(MB + 4, 32'h4, 4'h1);
    rdck("status_ovf_clr", MB + 4, 32'h0000_0002);

    // push into full FIFO with simultaneous pop
    rdy = 0;
    for (int i = 0; i < 8; i++) wr(MB, 32'h50 + i, 4'h1);
    rdy = 1;
    wr(MB, 32'h77, 4'h1);
    rdy = 0;
    rdck("status_full_pop_push", MB + 4, 32'h0000_0081);
    rdy = 1;
    repeat (9) idle();
    check("last_entry_gone", last_cv, 1'b0);

    // reset mid-drain
    rdy = 0;
    for (int i = 0; i < 4; i++) wr(MB, 32'h60 + i, 4'h1);
    rdy = 1;
    repeat (2) idle();
    cyc(MB, 32'h99, 1'b1, 4'h1, 1'b1, 1'b1);
    rdck("clr_cycle", MB + 8, 32'd0);
    check("clr_valid", last_cv, 1'b0);

    // 32-bit carry into high word
    force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.r_cycle;
    m_cyc = 64'h0000_0000_FFFF_FFFF + 64'd1;
    rdck("wrap_lo", MB + 8, 32'd0);
    rdck("wrap_hi", MB + 12, 32'd1);

    // randomized traffic
    for (int k = 0; k < 16; k++) wr(32'h200 + 4 * k, $urandom, 4'hF);
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ad;
      int op;
      op = $urandom_range(0, 9);
      rdy = 1'($urandom_range(0, 1));
      ad = 32'h200 + 32'(4 * $urandom_range(0, 15)) + 32'(4 * DW * $urandom_range(0, 3));
      case (op)
        0, 1, 2: wr(ad, $urandom, 4'($urandom));
        3, 4:    cyc(ad, 32'h0, 1'b0, 4'h0, rdy, 1'b0);
        5, 6:    wr(MB, $urandom, 4'($urandom_range(0, 15)));
        7:       wr(MB + 32'(4 * $urandom_range(1, 3)), $urandom, 4'($urandom));
        8:       cyc(MB + 32'(4 * $urandom_range(0, 3)), 32'h0, 1'b0, 4'h0, rdy, 1'b0);
        default: cyc(32'h0, 32'h0, 1'b0, 4'h0, rdy, ($urandom_range(0, 19) == 0));
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
